pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Owns the architectural PC. Issues instruction-memory requests and delivers fetched words to decode.
//  Consumes PC redirects from the jump/branch units: pc_update_control/pc_update_val map to
//  redirect_valid/redirect_pc. Squashes wrong-path fetches. Sits between imem and decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
// PORTS
//  i_clk           in   1   clock; all state updates on posedge
//  i_rst           in   1   asynchronous, active-high reset
//  redirect_valid  in   1   redirect request (pc_update_control)
//  redirect_pc     in   32  redirect target (pc_update_val)
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts request this cycle
//  imem_req_addr   out  32  fetch address
//  imem_rsp_valid  in   1   fetch response valid (in order, >=1 cycle after accept)
//  imem_rsp_data   in   32  fetched instruction word
//  inst_valid      out  1   instruction to decode valid
//  inst_ready      in   1   decode accepts instruction
//  inst_data       out  32  instruction word
//  inst_pc         out  32  PC of inst_data
//  fetch_fault     out  1   misaligned redirect target seen; sticky
// BEHAVIOUR
//  Reset (async, i_rst=1):
//   - pc=RESET_PC, state=REQ, squash=0.
//   - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0.
//   - imem_req_valid rises the first cycle after reset deasserts.
//  Outstanding requests: at most 1. req_pc holds the address of the accepted request.
//  FSM states: REQ, WAIT, HOLD, FAULT.
//   REQ:
//    - imem_req_valid=1, imem_req_addr=pc.
//    - On imem_req_ready: req_pc<=pc, go WAIT.
//    - Address may change while unaccepted (redirect); imem must not assume it is stable.
//   WAIT:
//    - imem_req_valid=0.
//    - On imem_rsp_valid with squash=1: drop the word, squash<=0, go REQ.
//    - On imem_rsp_valid with squash=0: inst_valid<=1, inst_data<=rsp_data, inst_pc<=req_pc,
//      pc<=req_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), go HOLD.
//   HOLD:
//    - Output register full.
//    - On inst_valid&&inst_ready: inst_valid<=0, go REQ. The next request is issued the following cycle.
//   FAULT:
//    - No requests issued; fetch_fault=1; inst_valid=0.
//  imem_rsp_valid outside WAIT is ignored (covers late responses after reset).
//  Redirect (redirect_valid=1) has priority over every other event in the same cycle:
//   - pc<=redirect_pc; inst_valid<=0.
//   - A simultaneous inst handshake still counts as delivered.
//   - In WAIT, or in REQ with imem_req_ready=1 the same cycle: squash<=1, state=WAIT.
//   - Otherwise state<=REQ.
//   - If redirect_pc[1:0]!=0: state<=FAULT, fetch_fault<=1, squash set as above but ignored.
//   - An aligned redirect while in FAULT clears fetch_fault and goes REQ; a pending squash still waits in WAIT.
//  Latency:
//   - Request accepted at cycle N, response at N+1 -> inst_valid at N+2.
//   - Redirect at cycle R -> imem_req_addr=redirect_pc at R+1 (R+2 or later if squashing).
//  Back-to-back redirects: the last one wins; squash stays 1 until the single outstanding response returns.
// STRUCTURE
//  Shared package (processor_defines):
//   - fetch_state_t enum {REQ,WAIT,HOLD,FAULT}.
//   - RESET_PC default value.
//   - INST_BYTES=4.
//  Sub-module fetch_out_buf: 1-entry valid/ready register for inst_valid/inst_data/inst_pc,
//  with a synchronous flush input.
//  Top level holds the FSM, pc, req_pc and squash.
// TESTING
//  1. Reset, imem ready=1, 1-cycle rsp, inst_ready=1 -> inst_pc sequence 0,4,8,... with inst_valid every 3rd cycle.
//  2. inst_ready=0 for 5 cycles in HOLD -> inst_valid/data/pc stable; no imem_req_valid until handshake.
//  3. Redirect to 32'h100 in WAIT; response 0xDEAD arrives 3 cycles later -> word dropped, next req addr 32'h100.
//  4. Redirect to 32'h102 -> fetch_fault=1, no requests; then redirect to 32'h200 -> fault cleared, req addr 32'h200.
//  5. Redirect same cycle as inst handshake in HOLD -> handshake counted, inst_valid=0 next cycle, req addr=target.
//  6. i_rst asserted in WAIT, response returns during/after reset -> ignored; first req addr=RESET_PC.

Source files
------------

// File: rtl/processor_defines.sv
// Shared fetch definitions: FSM state encoding, default reset PC and
// instruction width in bytes.
package processor_defines;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready output register carrying a fetched instruction and
// its PC towards decode.
//   clk, rst    clock / asynchronous active-high reset
//   load        capture word and pc, raise valid
//   load_data   instruction word to capture
//   load_pc     PC of the captured word
//   flush       synchronous drop of the held entry (wins over load)
//   ready       downstream accepts the entry
//   valid       entry held
//   data, pc    held instruction word and its PC
module fetch_out_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    input  logic        flush,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch front end: owns the architectural PC, issues one
// instruction-memory request at a time, squashes wrong-path responses after
// redirects and hands fetched words to decode.
//   i_clk, i_rst                      clock / asynchronous active-high reset
//   redirect_valid, redirect_pc       PC redirect from jump/branch units
//   imem_req_valid/ready/addr         fetch request channel
//   imem_rsp_valid/data               in-order fetch response
//   inst_valid/ready/data/pc          instruction channel to decode
//   fetch_fault                       sticky misaligned-redirect flag
module pc_fetch
    import processor_defines::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  req_pc, req_pc_n;
    logic         squash, squash_n;
    logic         fault, fault_n;
    logic         pending;
    logic         buf_load, buf_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            squash <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            req_pc <= req_pc_n;
            squash <= squash_n;
            fault  <= fault_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        req_pc_n  = req_pc;
        squash_n  = squash;
        fault_n   = fault;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        pending   = 1'b0;

        if (state == REQ && imem_req_ready) begin
            req_pc_n = pc;
        end

        // pending: a request is still in flight after this cycle. A response
        // arriving in the same cycle as a redirect retires the in-flight
        // request, so it must not leave a squash waiting for a second one.
        case (state)
            REQ:     pending = imem_req_ready;
            WAIT:    pending = !imem_rsp_valid;
            FAULT:   pending = squash && !imem_rsp_valid;
            default: pending = 1'b0;
        endcase

        if (redirect_valid) begin
            pc_n      = redirect_pc;
            buf_flush = 1'b1;
            squash_n  = pending;
            if (redirect_pc[1:0] != 2'b00) begin
                state_n = FAULT;
                fault_n = 1'b1;
            end else begin
                fault_n = 1'b0;
                state_n = pending ? WAIT : REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_ready) begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (squash) begin
                            squash_n = 1'b0;
                            state_n  = REQ;
                        end else begin
                            buf_load = 1'b1;
                            pc_n     = req_pc + INST_BYTES;
                            state_n  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_valid && inst_ready) begin
                        state_n = REQ;
                    end
                end
                FAULT: begin
                    // The squashed response may return while faulted; retire it
                    // here so a later aligned redirect does not wait for it.
                    if (squash && imem_rsp_valid) begin
                        squash_n = 1'b0;
                    end
                end
                default: state_n = REQ;
            endcase
        end
    end

    // Held low while reset is asserted so the first request appears only
    // once reset is released.
    assign imem_req_valid = (state == REQ) && !i_rst;
    assign imem_req_addr  = pc;
    assign fetch_fault    = fault;

    fetch_out_buf u_out_buf (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (buf_load),
        .load_data (imem_rsp_data),
        .load_pc   (req_pc),
        .flush     (buf_flush),
        .ready     (inst_ready),
        .valid     (inst_valid),
        .data      (inst_data),
        .pc        (inst_pc)
    );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, steady fetch, decode back-pressure,
// redirect squash, misaligned redirect fault, redirect during handshake and
// reset while a fetch is outstanding.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b1;

        // ---- 1. reset values, then steady fetch 0,4,8 ----
        tick();
        tick();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_fault", fetch_fault, 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            // REQ cycle
            chk("t1_req_valid", imem_req_valid, 1);
            chk("t1_req_addr", imem_req_addr, 32'(i * 4));
            chk("t1_inst_idle", inst_valid, 0);
            tick();
            // WAIT cycle: respond
            chk("t1_wait_noreq", imem_req_valid, 0);
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hA000_0000 + 32'(i * 4);
            tick();
            // HOLD cycle: delivered
            imem_rsp_valid = 1'b0;
            chk("t1_inst_valid", inst_valid, 1);
            chk("t1_inst_pc", inst_pc, 32'(i * 4));
            chk("t1_inst_data", inst_data, 32'hA000_0000 + 32'(i * 4));
            tick();
        end

        // ---- 2. decode stall for 5 cycles in HOLD ----
        chk("t2_req_addr", imem_req_addr, 32'h0000_000C);
        inst_ready = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", inst_valid, 1);
            chk("t2_hold_data", inst_data, 32'h1234_5678);
            chk("t2_hold_pc", inst_pc, 32'h0000_000C);
            chk("t2_hold_noreq", imem_req_valid, 0);
            tick();
        end
        inst_ready = 1'b1;
        chk("t2_hs_valid", inst_valid, 1);
        tick();
        chk("t2_after_inst", inst_valid, 0);
        chk("t2_after_req", imem_req_valid, 1);
        chk("t2_after_addr", imem_req_addr, 32'h0000_0010);

        // ---- 3. redirect to 0x100 while waiting; stale 0xDEAD dropped ----
        tick();
        chk("t3_wait", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("t3_sq1_noreq", imem_req_valid, 0);
        tick();
        chk("t3_sq2_noreq", imem_req_valid, 0);
        tick();
        chk("t3_sq3_noreq", imem_req_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_DEAD;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t3_dropped", inst_valid, 0);
        chk("t3_req_valid", imem_req_valid, 1);
        chk("t3_req_addr", imem_req_addr, 32'h0000_0100);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_0100;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t3_new_valid", inst_valid, 1);
        chk("t3_new_pc", inst_pc, 32'h0000_0100);
        chk("t3_new_data", inst_data, 32'hCAFE_0100);
        tick();
        chk("t3_next_addr", imem_req_addr, 32'h0000_0104);

        // ---- 4. misaligned redirect faults, aligned one recovers ----
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("t4_fault", fetch_fault, 1);
        chk("t4_noreq", imem_req_valid, 0);
        chk("t4_inst", inst_valid, 0);
        tick();
        tick();
        chk("t4_fault_sticky", fetch_fault, 1);
        chk("t4_noreq_sticky", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("t4_cleared", fetch_fault, 0);
        chk("t4_req_valid", imem_req_valid, 1);
        chk("t4_req_addr", imem_req_addr, 32'h0000_0200);

        // ---- 5. redirect in the same cycle as the decode handshake ----
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBEEF_0200;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t5_hs_valid", inst_valid, 1);
        chk("t5_hs_pc", inst_pc, 32'h0000_0200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        chk("t5_inst_clear", inst_valid, 0);
        chk("t5_req_valid", imem_req_valid, 1);
        chk("t5_req_addr", imem_req_addr, 32'h0000_0300);

        // ---- 6. reset while waiting; late response ignored ----
        tick();
        chk("t6_wait", imem_req_valid, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", imem_req_valid, 0);
        chk("t6_rst_inst", inst_valid, 0);
        chk("t6_rst_pc", inst_pc, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("t6_req_valid", imem_req_valid, 1);
        chk("t6_req_addr", imem_req_addr, 32'h0000_0000);
        tick();
        chk("t6_ignored", inst_valid, 0);
        chk("t6_still_req", imem_req_addr, 32'h0000_0000);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h600D_0000;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t6_first_valid", inst_valid, 1);
        chk("t6_first_pc", inst_pc, 32'h0000_0000);
        chk("t6_first_data", inst_data, 32'h600D_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
